// File: rtl/qspi_mem_responder.sv
// qspi_mem_responder
// ------------------
// Device end of a quad-SPI memory bus. Emulates a small QPI SRAM backed by an
// internal byte array and supports quad read (0xEB, with dummy cycles) and
// quad write (0x38). sck is oversampled by clk_i; cs_in, sck_i and sd_i pass
// through SYNC_STAGES synchronizer flops before any decoding.
//
// Ports
//   clk_i      system clock (>= 8x sck)
//   rst_i      synchronous reset, active high
//   cs_in      chip select, active low
//   sck_i      serial clock, idle low (mode 0)
//   sd_i[3:0]  quad data from the initiator
//   sd_o[3:0]  quad data to the initiator (changes after sck fall)
//   sd_oen_o   per-line drive enable, all ones while driving read data
//   bd_we_i    backdoor write strobe for preloading the array
//   bd_addr_i  backdoor byte address
//   bd_data_i  backdoor byte
module qspi_mem_responder #(
    parameter int DEPTH        = 256,
    parameter int DUMMY_CYCLES = 6,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cs_in,
    input  logic                     sck_i,
    input  logic [3:0]               sd_i,
    output logic [3:0]               sd_o,
    output logic [3:0]               sd_oen_o,
    input  logic                     bd_we_i,
    input  logic [$clog2(DEPTH)-1:0] bd_addr_i,
    input  logic [7:0]               bd_data_i
);

    localparam int AW  = $clog2(DEPTH);
    // Shift width covers both the 8-bit opcode and the used address bits.
    localparam int SW  = (AW > 8) ? AW : 8;
    localparam int DCW = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;
    localparam logic [DCW-1:0] DUMMY_LAST = DCW'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0]      cs_sync_reg,  cs_sync_next;
    logic [SYNC_STAGES-1:0]      sck_sync_reg, sck_sync_next;
    logic [SYNC_STAGES-1:0][3:0] sd_sync_reg,  sd_sync_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign cs_sync_next[gi]  = cs_in;
                assign sck_sync_next[gi] = sck_i;
                assign sd_sync_next[gi]  = sd_i;
            end else begin : g_rest
                assign cs_sync_next[gi]  = cs_sync_reg[gi-1];
                assign sck_sync_next[gi] = sck_sync_reg[gi-1];
                assign sd_sync_next[gi]  = sd_sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_sync_reg  <= '1;
            sck_sync_reg <= '0;
            sd_sync_reg  <= '0;
        end else begin
            cs_sync_reg  <= cs_sync_next;
            sck_sync_reg <= sck_sync_next;
            sd_sync_reg  <= sd_sync_next;
        end
    end

    logic       cs_s, sck_s;
    logic [3:0] sd_s;
    assign cs_s  = cs_sync_reg[SYNC_STAGES-1];
    assign sck_s = sck_sync_reg[SYNC_STAGES-1];
    assign sd_s  = sd_sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Edge detection and cs arming
    // ------------------------------------------------------------------
    // After reset the synchronizer holds a fake "cs high". flush_reg waits
    // until the chain reflects the real pin; armed_reg then requires a real
    // high level on cs before a fall may open a transaction, so a cs already
    // low at reset release is ignored until it rises and falls again.
    logic                   sck_prev_reg;
    logic                   cs_prev_reg;
    logic [SYNC_STAGES-1:0] flush_reg;
    logic                   armed_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_prev_reg <= 1'b0;
            cs_prev_reg  <= 1'b1;
            flush_reg    <= '0;
            armed_reg    <= 1'b0;
        end else begin
            sck_prev_reg <= sck_s;
            cs_prev_reg  <= cs_s;
            flush_reg    <= (flush_reg << 1) | SYNC_STAGES'(1);
            if (flush_reg[SYNC_STAGES-1] && cs_s)
                armed_reg <= 1'b1;
        end
    end

    logic sck_rise, sck_fall, cs_fall;
    assign sck_rise = sck_s & ~sck_prev_reg & ~cs_s;
    assign sck_fall = ~sck_s & sck_prev_reg & ~cs_s;
    assign cs_fall  = armed_reg & cs_prev_reg & ~cs_s;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_t          state_reg;
    logic [2:0]      nib_cnt_reg;
    logic [SW-5:0]   shift_reg;
    logic [SW-1:0]   shift_next;
    logic            is_read_reg;
    logic [AW-1:0]   addr_reg;
    logic [DCW-1:0]  dummy_cnt_reg;
    logic            rd_phase_reg;   // 0: high nibble next, 1: low nibble next
    logic            wr_half_reg;    // 1: high nibble of the write byte held
    logic [3:0]      wr_hi_reg;
    logic            load_req_reg;   // refresh rd_byte_reg from addr_reg
    logic [7:0]      rd_byte_reg;

    assign shift_next = {shift_reg, sd_s};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            nib_cnt_reg   <= '0;
            shift_reg     <= '0;
            is_read_reg   <= 1'b0;
            addr_reg      <= '0;
            dummy_cnt_reg <= '0;
            rd_phase_reg  <= 1'b0;
            wr_half_reg   <= 1'b0;
            wr_hi_reg     <= '0;
            load_req_reg  <= 1'b0;
            sd_o          <= '0;
            sd_oen_o      <= '0;
        end else begin
            load_req_reg <= 1'b0;
            if (cs_s) begin
                // Deselect aborts everything; partial bytes are dropped.
                state_reg    <= ST_IDLE;
                sd_oen_o     <= '0;
                nib_cnt_reg  <= '0;
                rd_phase_reg <= 1'b0;
                wr_half_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_reg   <= ST_CMD;
                            nib_cnt_reg <= '0;
                            shift_reg   <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            shift_reg <= shift_next[SW-5:0];
                            if (nib_cnt_reg == 3'd1) begin
                                nib_cnt_reg <= '0;
                                if (shift_next[7:0] == 8'hEB) begin
                                    is_read_reg <= 1'b1;
                                    state_reg   <= ST_ADDR;
                                end else if (shift_next[7:0] == 8'h38) begin
                                    is_read_reg <= 1'b0;
                                    state_reg   <= ST_ADDR;
                                end else begin
                                    state_reg   <= ST_IGNORE;
                                end
                            end else begin
                                nib_cnt_reg <= nib_cnt_reg + 3'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            shift_reg <= shift_next[SW-5:0];
                            if (nib_cnt_reg == 3'd5) begin
                                nib_cnt_reg <= '0;
                                addr_reg    <= shift_next[AW-1:0];
                                if (!is_read_reg) begin
                                    state_reg   <= ST_WDATA;
                                    wr_half_reg <= 1'b0;
                                end else if (DUMMY_CYCLES == 0) begin
                                    state_reg    <= ST_RDATA;
                                    rd_phase_reg <= 1'b0;
                                    load_req_reg <= 1'b1;
                                end else begin
                                    state_reg     <= ST_DUMMY;
                                    dummy_cnt_reg <= '0;
                                end
                            end else begin
                                nib_cnt_reg <= nib_cnt_reg + 3'd1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sck_rise) begin
                            if (dummy_cnt_reg == DUMMY_LAST) begin
                                state_reg    <= ST_RDATA;
                                rd_phase_reg <= 1'b0;
                                load_req_reg <= 1'b1;
                            end else begin
                                dummy_cnt_reg <= dummy_cnt_reg + DCW'(1);
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (sck_fall) begin
                            sd_oen_o <= 4'hF;
                            if (!rd_phase_reg) begin
                                sd_o         <= rd_byte_reg[7:4];
                                rd_phase_reg <= 1'b1;
                            end else begin
                                sd_o         <= rd_byte_reg[3:0];
                                rd_phase_reg <= 1'b0;
                                addr_reg     <= addr_reg + AW'(1);
                                load_req_reg <= 1'b1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sck_rise) begin
                            if (!wr_half_reg) begin
                                wr_hi_reg   <= sd_s;
                                wr_half_reg <= 1'b1;
                            end else begin
                                wr_half_reg <= 1'b0;
                                addr_reg    <= addr_reg + AW'(1);
                            end
                        end
                    end
                    default: begin
                        // ST_IGNORE: wait for deselect.
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte array: one write port shared by bus writes and the backdoor
    // (bus commit has priority), one registered read port.
    // ------------------------------------------------------------------
    logic [7:0] mem [DEPTH];
    logic       wr_commit;
    assign wr_commit = (state_reg == ST_WDATA) && sck_rise && wr_half_reg;

    always_ff @(posedge clk_i) begin
        if (wr_commit)
            mem[addr_reg] <= {wr_hi_reg, sd_s};
        else if (bd_we_i)
            mem[bd_addr_i] <= bd_data_i;
        if (load_req_reg)
            rd_byte_reg <= mem[addr_reg];
    end

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Testbench for qspi_mem_responder: directed QSPI transactions driven at the
// pins, a byte-array model of the memory, and a per-sck-cycle comparison of
// sd_o / sd_oen_o against the expected read stream.
module tb_qspi_mem_responder;

    localparam int DEPTH = 256;
    localparam int DUMMY = 6;
    localparam int SYNC  = 2;
    localparam int HALF  = 8;   // clk_i cycles per sck half period

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n;
    logic       sck;
    logic [3:0] sd_in;
    logic [3:0] sd_out;
    logic [3:0] sd_oen;
    logic       bd_we;
    logic [7:0] bd_addr;
    logic [7:0] bd_data;

    always #5 clk = ~clk;

    qspi_mem_responder #(
        .DEPTH        (DEPTH),
        .DUMMY_CYCLES (DUMMY),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .cs_in     (cs_n),
        .sck_i     (sck),
        .sd_i      (sd_in),
        .sd_o      (sd_out),
        .sd_oen_o  (sd_oen),
        .bd_we_i   (bd_we),
        .bd_addr_i (bd_addr),
        .bd_data_i (bd_data)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mem_model [DEPTH];
    logic [3:0] obs [32];
    int         obs_n;
    logic [3:0] exp_oen;
    logic [3:0] exp_sd;
    bit         exp_sd_valid;
    string      tag;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare the pins against the model's expectation for this sck cycle.
    task automatic compare_outputs();
        check({tag, " oen"}, {4'h0, sd_oen}, {4'h0, exp_oen});
        if (exp_sd_valid) begin
            check({tag, " sd"}, {4'h0, sd_out}, {4'h0, exp_sd});
            obs[obs_n] = sd_out;
            obs_n++;
        end
        $display("cycle %s: oen=%h sd=%h (exp oen=%h sd=%h valid=%0d)",
                 tag, sd_oen, sd_out, exp_oen, exp_sd, exp_sd_valid);
    endtask

    // One full sck period. Optionally fires a backdoor write exactly in the
    // clk_i cycle where the responder sees this rise (collision case).
    task automatic sck_cycle(input logic [3:0] nib, input bit coll, input logic [7:0] coll_data);
        sd_in = nib;
        tick(2);
        sck = 1'b1;
        if (coll) begin
            tick(2);
            bd_we = 1'b1; bd_addr = 8'h05; bd_data = coll_data;
            tick(1);
            bd_we = 1'b0;
            tick(HALF - 3);
        end else begin
            tick(HALF);
        end
        sck = 1'b0;
        tick(HALF);
        compare_outputs();
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_end();
        cs_n = 1'b1;
        tick(SYNC + 1);
        exp_oen = 4'h0; exp_sd_valid = 1'b0;
        tag = "deselect";
        compare_outputs();
        tick(4);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
        exp_oen = 4'h0; exp_sd_valid = 1'b0;
        tag = "hdr";
        for (int i = 0; i < 2; i++) sck_cycle(op[7-4*i -: 4], 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) sck_cycle(a[23-4*i -: 4], 1'b0, 8'h00);
    endtask

    // Cycles after the header: nibble n is driven on the fall of cycle
    // (DUMMY + n - 1) counted from the first dummy cycle.
    task automatic read_phase(input logic [23:0] a, input int ncyc, input bit live);
        int         n;
        logic [7:0] b;
        obs_n = 0;
        for (int c = 0; c < ncyc; c++) begin
            n = c + 1 - DUMMY;
            if (live && n >= 0) begin
                b = mem_model[(int'(a[7:0]) + n / 2) % DEPTH];
                exp_oen = 4'hF;
                exp_sd = (n % 2 == 0) ? b[7:4] : b[3:0];
                exp_sd_valid = 1'b1;
                tag = "rdata";
            end else begin
                exp_oen = 4'h0; exp_sd_valid = 1'b0;
                tag = live ? "dummy" : "idle";
            end
            sck_cycle(4'h0, 1'b0, 8'h00);
        end
    endtask

    task automatic read_txn(input logic [23:0] a, input int nbytes);
        cs_start();
        send_hdr(8'hEB, a);
        read_phase(a, DUMMY + 2 * nbytes - 1, 1'b1);
        cs_end();
    endtask

    task automatic write_txn(input logic [23:0] a, input int nbytes, input logic [15:0] d,
                             input bit coll, input logic [7:0] coll_data);
        logic [7:0] b;
        cs_start();
        send_hdr(8'h38, a);
        tag = "wdata";
        for (int i = 0; i < nbytes; i++) begin
            b = d[15-8*i -: 8];
            sck_cycle(b[7:4], 1'b0, 8'h00);
            sck_cycle(b[3:0], coll && (i == 0), coll_data);
            mem_model[(int'(a[7:0]) + i) % DEPTH] = b;
        end
        cs_end();
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        tick(1);
        bd_we = 1'b0;
        mem_model[a] = d;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h00;
        rst = 1'b1; cs_n = 1'b1; sck = 1'b0; sd_in = 4'h0;
        bd_we = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;
        exp_oen = 4'h0; exp_sd = 4'h0; exp_sd_valid = 1'b0; tag = "reset"; obs_n = 0;
        tick(4);
        rst = 1'b0;
        tick(1);
        check("reset sd_o", {4'h0, sd_out}, 8'h00);
        check("reset sd_oen_o", {4'h0, sd_oen}, 8'h00);

        // Quad write then read back.
        write_txn(24'h000010, 2, 16'hA53C, 1'b0, 8'h00);
        read_txn(24'h000010, 2);
        check("wr/rd nib0", {4'h0, obs[0]}, 8'h0A);
        check("wr/rd nib1", {4'h0, obs[1]}, 8'h05);
        check("wr/rd nib2", {4'h0, obs[2]}, 8'h03);
        check("wr/rd nib3", {4'h0, obs[3]}, 8'h0C);

        // Address wrap DEPTH-1 -> 0.
        write_txn(24'h0000FF, 1, 16'h1100, 1'b0, 8'h00);
        write_txn(24'h000000, 1, 16'h2200, 1'b0, 8'h00);
        read_txn(24'h0000FF, 2);
        check("wrap byte0", {obs[0], obs[1]}, 8'h11);
        check("wrap byte1", {obs[2], obs[3]}, 8'h22);

        // Unknown opcode: no drive, no write (payload would hit 0x10).
        cs_start();
        send_hdr(8'h9F, 24'h000010);
        tag = "ignore";
        sck_cycle(4'h7, 1'b0, 8'h00);
        sck_cycle(4'h7, 1'b0, 8'h00);
        cs_end();
        read_txn(24'h000010, 1);
        check("ignore mem", {obs[0], obs[1]}, 8'hA5);

        // Abort after one data nibble: byte discarded.
        bd_write(8'h20, 8'h00);
        cs_start();
        send_hdr(8'h38, 24'h000020);
        tag = "partial";
        sck_cycle(4'h7, 1'b0, 8'h00);
        cs_end();
        read_txn(24'h000020, 1);
        check("abort mem", {obs[0], obs[1]}, 8'h00);

        // Backdoor preload and bus/backdoor collision.
        bd_write(8'h05, 8'hC3);
        read_txn(24'h000005, 1);
        check("bd nib0", {4'h0, obs[0]}, 8'h0C);
        check("bd nib1", {4'h0, obs[1]}, 8'h03);
        write_txn(24'h000005, 1, 16'h5A00, 1'b1, 8'hFF);
        read_txn(24'h000005, 1);
        check("collision", {obs[0], obs[1]}, 8'h5A);

        // Reset during the data phase.
        cs_start();
        send_hdr(8'hEB, 24'h000010);
        read_phase(24'h000010, DUMMY + 1, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("reset mid-read oen", {4'h0, sd_oen}, 8'h00);
        // cs still low after reset: a full read must be ignored.
        send_hdr(8'hEB, 24'h000010);
        read_phase(24'h000010, DUMMY + 3, 1'b0);
        cs_end();
        read_txn(24'h000010, 2);
        check("post-reset byte0", {obs[0], obs[1]}, 8'hA5);
        check("post-reset byte1", {obs[2], obs[3]}, 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qspi_mem_responder.md
Name: qspi_mem_responder

Overview:
- Synthesizable QSPI memory responder: the device end of the SoC's quad-SPI memory bus (cs_n / sck / 4-bit sd).
- Emulates a small QPI SRAM backed by an internal byte array; supports quad read and quad write.
- Used as an on-board/FPGA stand-in for external ROM/RAM; one instance per chip select.
- sck is oversampled by clk_i. No clock-domain crossing beyond the input synchronizers.

Parameters:
- DEPTH, 256, memory size in bytes; power of two; address taken modulo DEPTH.
- DUMMY_CYCLES, 6, sck cycles between last address nibble and first read nibble (0xEB only).
- SYNC_STAGES, 2, synchronizer flops on cs_in, sck_i and sd_i.

Ports:
- clk_i  in  1  system clock; must be >= 8x sck frequency.
- rst_i  in  1  synchronous reset, active high.
- cs_in  in  1  chip select from initiator, active low.
- sck_i  in  1  serial clock from initiator, idle low (mode 0).
- sd_i  in  4  quad data from initiator.
- sd_o  out  4  quad data to initiator.
- sd_oen_o  out  4  output enable per line, 1 = drive; always all-ones or all-zeros.
- bd_we_i  in  1  backdoor write strobe (preload), sampled each clk_i.
- bd_addr_i  in  $clog2(DEPTH)  backdoor byte address.
- bd_data_i  in  8  backdoor byte.

Behaviour:
- Reset: state IDLE, sd_o = 0, sd_oen_o = 0, address/shift registers cleared. Memory contents not cleared. Synchronizers reset to cs high, sck low.
- Edge detection: rise/fall pulses derived from the synchronized sck, 1 clk_i wide. Events are ignored while synchronized cs is high.
- Input sampling and output drive:
  - Nibbles are captured on sck rise.
  - sd_o/sd_oen_o update on sck fall.
  - Pin-to-pin latency is SYNC_STAGES+1 clk_i.
- Bit order: high nibble first; address 24 bits MSB first; only the low $clog2(DEPTH) bits are used.
- FSM:
  - IDLE -> CMD on synchronized cs fall.
  - CMD: 2 nibbles form the opcode. 0xEB -> ADDR(read); 0x38 -> ADDR(write); else -> IGNORE.
  - ADDR: 6 nibbles; after the 6th, -> DUMMY for read (RDATA directly if DUMMY_CYCLES=0), -> WDATA for write.
  - DUMMY: count DUMMY_CYCLES rises, then -> RDATA.
  - RDATA: on each fall, drive the next nibble of mem[addr] with sd_oen_o=4'hF. The first fall after DUMMY drives the high nibble. After the low nibble is driven, addr increments modulo DEPTH (wrap DEPTH-1 -> 0).
  - WDATA: on each second rise, commit {first,second} nibble to mem[addr], then addr increments modulo DEPTH.
  - IGNORE: no drive, no writes.
- cs rise in any state:
  - -> IDLE next clk_i; sd_oen_o = 0 same cycle.
  - Partial write byte (odd nibble count) is discarded.
  - Partial command/address is discarded.
- Simultaneous bd_we_i and a WDATA commit in the same clk_i: the WDATA commit wins; the backdoor write is dropped.
- RDATA sources the byte from a register loaded at the transition into RDATA and at each address increment. A backdoor write to the current read address during RDATA is not reflected until the next byte.
- rst_i mid-transaction: sd_oen_o = 0 at the next clk_i; FSM stays IDLE until the next cs fall (a cs already low at reset release is ignored until it rises and falls again).

Test Plan:
- Quad write then read: write cmd 0x38, addr 0x000010, data 0xA5,0x3C; cs high; read cmd 0xEB, addr 0x000010, 6 dummy cycles -> sd_o nibbles A,5,3,C with sd_oen_o=F only in data phase.
- Wrap: DEPTH=256, write 0x11 at 0xFF and 0x22 at 0x00; read 0xEB from 0x0000FF for 2 bytes -> 0x11 then 0x22.
- Unknown opcode 0x9F followed by 8 nibbles -> sd_oen_o stays 0; memory unchanged (verify via read).
- Abort: write 0x38 at 0x20 with one nibble 0x7, then cs high -> mem[0x20] keeps its prior value 0x00; next transaction decodes normally.
- Backdoor preload: bd_we_i with addr 0x05, data 0xC3 -> read 0xEB at 0x05 returns C,3; collision case: same-cycle bd write and WDATA commit to 0x05 -> WDATA byte kept.
- Reset mid-read: assert rst_i during RDATA -> sd_oen_o=0 one clk_i later; later cs fall with a valid read returns correct data.
